mem_arbiter: RTL and testbench

- Two-master arbiter sharing the single-port program/data memory of the comp system.
- Master 0 is the CPU core. Master 1 is the debug/loader port, which loads programs and peeks memory from the bench or UART.
- Sits between both masters and the memory array. Sequences one access at a time with a req/ack handshake and round-robin fairness.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Optional locking is enabled with the MEM_ARB_LOCK_EN macro (see mem_arbiter).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection for the two-master memory arbiter.
// A locked holder with a live request beats everything; otherwise a round-robin or fixed-priority tie-break applies.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       holder,
    input  logic [1:0] lock,
    output logic       winner,
    output logic       valid,
    output logic       locked
);

    always_comb begin
        winner = M_CPU;
        valid  = |req;
        locked = 1'b0;
        if (req[holder] && lock[holder]) begin
            winner = holder;
            locked = 1'b1;
        end else if (req == 2'b11) begin
            winner = (FIXED_PRIO != 0) ? M_CPU : ~last;
        end else if (req[M_DBG]) begin
            winner = M_DBG;
        end else begin
            winner = M_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter (CPU core and debug/loader) in front of a single-port synchronous memory.
// Define MEM_ARB_LOCK_EN to add m0_lock/m1_lock for atomic sequences and loader bursts.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MEM_ADDR_SIZE = 12,
    parameter int FIXED_PRIO    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef MEM_ARB_LOCK_EN
    input  logic                     m0_lock,
    input  logic                     m1_lock,
`endif
    input  logic                     m0_req,
    input  logic                     m0_wen,
    input  logic [MEM_ADDR_SIZE-1:0] m0_addr,
    input  logic [WIDTH-1:0]         m0_wdata,
    output logic [WIDTH-1:0]         m0_rdata,
    output logic                     m0_ack,
    input  logic                     m1_req,
    input  logic                     m1_wen,
    input  logic [MEM_ADDR_SIZE-1:0] m1_addr,
    input  logic [WIDTH-1:0]         m1_wdata,
    output logic [WIDTH-1:0]         m1_rdata,
    output logic                     m1_ack,
    output logic                     mem_cs,
    output logic                     mem_wen,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    output logic                     grant,
    output logic                     busy
);

    state_t     state;
    logic       last;
    logic       locked_grant;
    logic [1:0] lock_vec;
    logic       pick_win;
    logic       pick_valid;
    logic       pick_locked;

`ifdef MEM_ARB_LOCK_EN
    assign lock_vec = {m1_lock, m0_lock};
`else
    assign lock_vec = 2'b00;
`endif

    arb_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req    ({m1_req, m0_req}),
        .last   (last),
        .holder (grant),
        .lock   (lock_vec),
        .winner (pick_win),
        .valid  (pick_valid),
        .locked (pick_locked)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            last         <= M_CPU;
            locked_grant <= 1'b0;
            mem_cs       <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            grant        <= M_CPU;
            busy         <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        mem_cs       <= 1'b1;
                        mem_wen      <= pick_win ? m1_wen   : m0_wen;
                        mem_addr     <= pick_win ? m1_addr  : m0_addr;
                        mem_wdata    <= pick_win ? m1_wdata : m0_wdata;
                        grant        <= pick_win;
                        locked_grant <= pick_locked;
                        busy         <= 1'b1;
                        state        <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_cs  <= 1'b0;
                    mem_wen <= 1'b0;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    // Read data is captured on writes too; the memory decides old or new word.
                    if (grant == M_DBG) begin
                        m1_rdata <= mem_rdata;
                        m1_ack   <= 1'b1;
                    end else begin
                        m0_rdata <= mem_rdata;
                        m0_ack   <= 1'b1;
                    end
                    if (FIXED_PRIO == 0 && !locked_grant) begin
                        last <= grant;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance (a_*) and a fixed-priority instance (b_*)
// share master stimulus, each backed by its own read-before-write memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [11:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
`ifdef MEM_ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif

    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
    logic        a_m0_ack, a_m1_ack, a_mem_cs, a_mem_wen, a_grant, a_busy;
    logic [11:0] a_mem_addr;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_m0_ack, b_m1_ack, b_mem_cs, b_mem_wen, b_grant, b_busy;
    logic [11:0] b_mem_addr;

    logic [31:0] mem_a [0:4095];
    logic [31:0] mem_b [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.WIDTH(32), .MEM_ADDR_SIZE(12), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .reset(reset),
`ifdef MEM_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack),
        .mem_cs(a_mem_cs), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .grant(a_grant), .busy(a_busy)
    );

    mem_arbiter #(.WIDTH(32), .MEM_ADDR_SIZE(12), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .reset(reset),
`ifdef MEM_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
        .mem_cs(b_mem_cs), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .grant(b_grant), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
    end

    // Synchronous single-port memories: read returns the word before any write in the same access.
    always @(posedge clk) begin
        if (a_mem_cs) begin
            if (a_mem_wen) mem_a[a_mem_addr] <= a_mem_wdata;
            a_mem_rdata <= mem_a[a_mem_addr];
        end
        if (b_mem_cs) begin
            if (b_mem_wen) mem_b[b_mem_addr] <= b_mem_wdata;
            b_mem_rdata <= mem_b[b_mem_addr];
        end
    end

    typedef struct {
        logic        mst;
        logic        wen;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        int          cyc;
        int          cs_n;
        int          wen_n;
        bit          got;
        logic [31:0] other_before;
        other_before = v.mst ? a_m0_rdata : a_m1_rdata;
        @(posedge clk); #1;
        if (v.mst) begin
            m1_req = 1'b1; m1_wen = v.wen; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_wen = v.wen; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        cyc = 0; cs_n = 0; wen_n = 0; got = 1'b0;
        while (!got && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (a_mem_cs) cs_n++;
            if (a_mem_cs && a_mem_wen) wen_n++;
            if (v.mst ? a_m1_ack : a_m0_ack) got = 1'b1;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check("txn_latency", 32'(cyc), 32'd3);
        check("txn_cs_width", 32'(cs_n), 32'd1);
        check("txn_wen_width", 32'(wen_n), v.wen ? 32'd1 : 32'd0);
        check("txn_rdata", v.mst ? a_m1_rdata : a_m0_rdata, v.exp_rdata);
        check("txn_grant", 32'(a_grant), 32'(v.mst));
        check("txn_other_rdata", v.mst ? a_m0_rdata : a_m1_rdata, other_before);
        check("txn_busy_clear", 32'(a_busy), 32'd0);
        if (v.wen) check("txn_mem_word", mem_a[v.addr], v.wdata);
    endtask

    initial begin
        int acks;
        int last_cyc;
        int n0;
        int n1;
        int m1_cyc;
        int cyc;
        bit got;

        vt[0] = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h00000000};
        vt[1] = '{1'b1, 1'b0, 12'h010, 32'h00000000, 32'hDEADBEEF};
        vt[2] = '{1'b1, 1'b1, 12'h020, 32'h12345678, 32'h00000000};
        vt[3] = '{1'b0, 1'b0, 12'h020, 32'h00000000, 32'h12345678};
        vt[4] = '{1'b0, 1'b1, 12'h010, 32'hCAFEF00D, 32'hDEADBEEF};
        vt[5] = '{1'b1, 1'b0, 12'h010, 32'h00000000, 32'hCAFEF00D};
        vt[6] = '{1'b0, 1'b1, 12'hFFF, 32'hA5A5A5A5, 32'h00000000};
        vt[7] = '{1'b0, 1'b0, 12'hFFF, 32'h00000000, 32'hA5A5A5A5};
        vt[8] = '{1'b1, 1'b0, 12'h000, 32'h00000000, 32'h00000000};

        reset = 1'b0;
        m0_req = 1'b0; m0_wen = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wen = 1'b0; m1_addr = '0; m1_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_cs", 32'(a_mem_cs | a_mem_wen | b_mem_cs | b_mem_wen), 32'd0);
        check("rst_mem_addr", 32'(a_mem_addr | b_mem_addr), 32'd0);
        check("rst_mem_wdata", a_mem_wdata | b_mem_wdata, 32'd0);
        check("rst_rdata", a_m0_rdata | a_m1_rdata | b_m0_rdata | b_m1_rdata, 32'd0);
        check("rst_ack", 32'(a_m0_ack | a_m1_ack | b_m0_ack | b_m1_ack), 32'd0);
        check("rst_grant_busy", 32'({a_grant, a_busy, b_grant, b_busy}), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(vt[i]);

        // Both masters hold read requests: grants must alternate starting with master 1.
        reset_pulse();
        @(posedge clk); #1;
        m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 12'h010;
        m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 12'h020;
        acks = 0; last_cyc = 0;
        for (int c = 1; c <= 20 && acks < 4; c++) begin
            @(posedge clk); #1;
            if (a_m0_ack || a_m1_ack) begin
                check("rr_grant", 32'(a_grant), (acks % 2 == 0) ? 32'd1 : 32'd0);
                check("rr_ack_owner", 32'(a_m1_ack), (acks % 2 == 0) ? 32'd1 : 32'd0);
                check("rr_spacing", 32'(c - last_cyc), 32'd3);
                last_cyc = c;
                acks++;
                if (acks == 4) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end
        end
        check("rr_ack_count", 32'(acks), 32'd4);
        check("rr_m0_rdata", a_m0_rdata, 32'hCAFEF00D);
        check("rr_m1_rdata", a_m1_rdata, 32'h12345678);
        @(posedge clk); #1;
        check("rr_ack_pulse", 32'(a_m0_ack | a_m1_ack), 32'd0);

        // Fixed-priority instance: master 0 keeps winning until it drops its request.
        reset_pulse();
        @(posedge clk); #1;
        m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 12'h010;
        m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 12'h020;
        n0 = 0; m1_cyc = 0; got = 1'b0;
        for (int c = 1; c <= 30 && !got; c++) begin
            @(posedge clk); #1;
            if (b_m0_ack) begin
                n0++;
                if (n0 == 3) m0_req = 1'b0;
            end
            if (b_m1_ack) begin
                got = 1'b1;
                m1_cyc = c;
                check("fp_m1_grant", 32'(b_grant), 32'd1);
                m1_req = 1'b0;
            end
        end
        check("fp_m0_count", 32'(n0), 32'd3);
        check("fp_m1_cycle", 32'(m1_cyc), 32'd12);

        // Reset during ACCESS of a master 1 read, then a retry.
        reset_pulse();
        @(posedge clk); #1;
        m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 12'h010;
        @(posedge clk); #1;
        check("mid_access_cs", 32'({a_mem_cs, a_busy, a_grant}), 32'b111);
        reset = 1'b0;
        #1;
        check("mid_rst_ctrl", 32'({a_mem_cs, a_mem_wen, a_busy, a_grant, a_m0_ack, a_m1_ack}), 32'd0);
        check("mid_rst_data", a_m1_rdata | a_m0_rdata | a_mem_wdata | 32'(a_mem_addr), 32'd0);
        n1 = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (a_m1_ack) n1++;
        end
        check("mid_rst_no_ack", 32'(n1), 32'd0);
        reset = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (a_m1_ack) got = 1'b1;
        end
        m1_req = 1'b0;
        check("retry_latency", 32'(cyc), 32'd3);
        check("retry_rdata", a_m1_rdata, 32'hCAFEF00D);

`ifdef MEM_ARB_LOCK_EN
        // Master 1 locks for four reads while master 0 waits.
        reset_pulse();
        @(posedge clk); #1;
        m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 12'h010;
        m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 12'h020; m1_lock = 1'b1;
        n1 = 0; m1_cyc = 0; got = 1'b0;
        for (int c = 1; c <= 30 && !got; c++) begin
            @(posedge clk); #1;
            if (a_m1_ack) begin
                n1++;
                if (n1 == 4) begin
                    m1_req = 1'b0;
                    m1_lock = 1'b0;
                end
            end
            if (a_m0_ack) begin
                got = 1'b1;
                m1_cyc = c;
                check("lock_m1_before_m0", 32'(n1), 32'd4);
                m0_req = 1'b0;
            end
        end
        check("lock_m0_cycle", 32'(m1_cyc), 32'd15);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
